// File: rtl/led_ctrl.sv
// led_ctrl: N-channel LED driver; each channel runs OFF, ON, BLINK or PWM.
// Outputs are registered. Out of reset every channel blinks at DEFAULT_HALF.
module led_ctrl #(
   parameter int          N_LEDS       = 4,
   parameter int          CNT_W        = 32,
   parameter int          PWM_W        = 8,
   parameter int unsigned DEFAULT_HALF = 32'd50_000_000,
   localparam int         SEL_W        = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [SEL_W-1:0]  cfg_sel,
   input  logic [1:0]        cfg_mode,
   input  logic [CNT_W-1:0]  cfg_half,
   input  logic [PWM_W-1:0]  cfg_duty,
   input  logic              sync,
   output logic [N_LEDS-1:0] leds,
   output logic [N_LEDS-1:0] toggle
);

   typedef enum logic [1:0] {
      MODE_OFF   = 2'b00,
      MODE_ON    = 2'b01,
      MODE_BLINK = 2'b10,
      MODE_PWM   = 2'b11
   } mode_e;

   mode_e             mode_r  [N_LEDS];
   mode_e             mode_s  [N_LEDS];
   logic [CNT_W-1:0]  half_r  [N_LEDS];
   logic [CNT_W-1:0]  half_s  [N_LEDS];
   logic [CNT_W-1:0]  cnt_r   [N_LEDS];
   logic [CNT_W-1:0]  cnt_s   [N_LEDS];
   logic [PWM_W-1:0]  duty_r  [N_LEDS];
   logic [PWM_W-1:0]  duty_s  [N_LEDS];
   logic [N_LEDS-1:0] phase_r;
   logic [N_LEDS-1:0] phase_s;
   logic [N_LEDS-1:0] leds_r;
   logic [N_LEDS-1:0] leds_s;
   logic [N_LEDS-1:0] toggle_r;
   logic [N_LEDS-1:0] toggle_s;
   logic [PWM_W-1:0]  pwm_cnt_r;
   logic [SEL_W:0]    sel_ext_s;
   logic              cfg_ok_s;

   // Widened select so an out-of-range index is detectable even when N_LEDS is a power of two.
   assign sel_ext_s = {1'b0, cfg_sel};
   assign cfg_ok_s  = cfg_we && (sel_ext_s < (SEL_W+1)'(N_LEDS));

   // Per-channel next state: write beats sync, sync beats counting; LED drive uses current state.
   always_comb begin
      mode_s   = mode_r;
      half_s   = half_r;
      duty_s   = duty_r;
      cnt_s    = cnt_r;
      phase_s  = phase_r;
      leds_s   = {N_LEDS{1'b0}};
      toggle_s = {N_LEDS{1'b0}};
      for (int i = 0; i < N_LEDS; i++) begin
         case (mode_r[i])
            MODE_OFF:   leds_s[i] = 1'b0;
            MODE_ON:    leds_s[i] = 1'b1;
            MODE_BLINK: leds_s[i] = phase_r[i];
            MODE_PWM:   leds_s[i] = (pwm_cnt_r < duty_r[i]);
            default:    leds_s[i] = 1'b0;
         endcase
         if (cfg_ok_s && (sel_ext_s == (SEL_W+1)'(i))) begin
            mode_s[i]  = mode_e'(cfg_mode);
            half_s[i]  = cfg_half;
            duty_s[i]  = cfg_duty;
            cnt_s[i]   = {CNT_W{1'b0}};
            phase_s[i] = 1'b0;
         end else if (sync) begin
            cnt_s[i]   = {CNT_W{1'b0}};
            phase_s[i] = 1'b0;
         end else if (mode_r[i] == MODE_BLINK) begin
            if (cnt_r[i] == half_r[i]) begin
               cnt_s[i]    = {CNT_W{1'b0}};
               phase_s[i]  = ~phase_r[i];
               toggle_s[i] = 1'b1;
            end else begin
               cnt_s[i] = cnt_r[i] + CNT_W'(1);
            end
         end else begin
            cnt_s[i] = {CNT_W{1'b0}};
         end
      end
   end

   // State and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_LEDS; i++) begin
            mode_r[i] <= MODE_BLINK;
            half_r[i] <= CNT_W'(DEFAULT_HALF);
            duty_r[i] <= {PWM_W{1'b0}};
            cnt_r[i]  <= {CNT_W{1'b0}};
         end
         phase_r   <= {N_LEDS{1'b0}};
         leds_r    <= {N_LEDS{1'b0}};
         toggle_r  <= {N_LEDS{1'b0}};
         pwm_cnt_r <= {PWM_W{1'b0}};
      end else begin
         mode_r    <= mode_s;
         half_r    <= half_s;
         duty_r    <= duty_s;
         cnt_r     <= cnt_s;
         phase_r   <= phase_s;
         leds_r    <= leds_s;
         toggle_r  <= toggle_s;
         pwm_cnt_r <= pwm_cnt_r + PWM_W'(1);
      end
   end

   assign leds   = leds_r;
   assign toggle = toggle_r;

endmodule

// File: tb/tb_led_ctrl.sv
// Directed bench for led_ctrl: vector table for reset/blink/write behaviour,
// plus hand sequences for PWM, half=0, sync, out-of-range select and async reset.
module tb_led_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       cfg_we;
   logic       cfg_we5;
   logic [1:0] cfg_sel;
   logic [2:0] cfg_sel5;
   logic [1:0] cfg_mode;
   logic [31:0] cfg_half;
   logic [7:0] cfg_duty;
   logic       sync;
   logic [3:0] leds;
   logic [3:0] toggle;
   logic [4:0] leds5;
   logic [4:0] toggle5;

   int cyc = 0;
   int total = 0;
   int bad = 0;

   typedef struct {
      logic       we;
      logic [1:0] sel;
      logic [1:0] mode;
      logic       sync;
      logic [3:0] exp_leds;
      logic [3:0] exp_tog;
   } vec_t;

   vec_t vecs[20];
   int   n;
   int   hi;
   int   tg;
   int   errs;
   logic [3:0] el;
   logic [3:0] et;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

   led_ctrl #(.N_LEDS(4), .CNT_W(32), .PWM_W(8), .DEFAULT_HALF(3)) u_dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_mode(cfg_mode),
      .cfg_half(cfg_half), .cfg_duty(cfg_duty), .sync(sync), .leds(leds), .toggle(toggle)
   );

   led_ctrl #(.N_LEDS(5), .CNT_W(32), .PWM_W(8), .DEFAULT_HALF(3)) u_dut5 (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we5), .cfg_sel(cfg_sel5), .cfg_mode(cfg_mode),
      .cfg_half(cfg_half), .cfg_duty(cfg_duty), .sync(1'b0), .leds(leds5), .toggle(toggle5)
   );

   // LED level after the n-th edge since a restart of a BLINK channel with half h.
   function automatic logic pat_led(input int k, input int h);
      return ((k - 1) % (2 * (h + 1))) >= (h + 1);
   endfunction

   function automatic logic pat_tog(input int k, input int h);
      return (k % (h + 1)) == 0;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic pwm_run(input logic [7:0] duty, input int exp_hi);
      cfg_we = 1'b1; cfg_sel = 2'd3; cfg_mode = 2'b11; cfg_duty = duty;
      step();
      cfg_we = 1'b0;
      step();
      hi = 0; tg = 0; errs = 0;
      for (int k = 0; k < 256; k++) begin
         step();
         hi += int'(leds[3]);
         tg += int'(toggle[3]);
         if (leds[0] !== pat_led(cyc, 3)) errs++;
      end
      check($sformatf("pwm%0d_high", duty), hi, exp_hi);
      check($sformatf("pwm%0d_toggle", duty), tg, 0);
      check($sformatf("pwm%0d_ch0_blink", duty), errs, 0);
   endtask

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_we5 = 1'b0; cfg_sel = 2'd0; cfg_sel5 = 3'd0;
      cfg_mode = 2'b00; cfg_half = 32'd3; cfg_duty = 8'd0; sync = 1'b0;

      // Vector table: edges 1..20 after release; ch1 -> ON at 13, ch2 -> OFF at 14.
      for (int k = 0; k < 20; k++) begin
         n = k + 1;
         vecs[k].we = 1'b0; vecs[k].sel = 2'd0; vecs[k].mode = 2'b00; vecs[k].sync = 1'b0;
         vecs[k].exp_leds = pat_led(n, 3) ? 4'hF : 4'h0;
         vecs[k].exp_tog  = pat_tog(n, 3) ? 4'hF : 4'h0;
         if (n == 13) begin vecs[k].we = 1'b1; vecs[k].sel = 2'd1; vecs[k].mode = 2'b01; end
         if (n == 14) begin vecs[k].we = 1'b1; vecs[k].sel = 2'd2; vecs[k].mode = 2'b00; end
         if (n >= 14) vecs[k].exp_leds[1] = 1'b1;
         if (n >= 15) vecs[k].exp_leds[2] = 1'b0;
         if (n >= 13) vecs[k].exp_tog[2:1] = 2'b00;
      end

      repeat (3) @(negedge clk);
      check("reset_leds", leds, 4'h0);
      check("reset_toggle", toggle, 4'h0);
      check("reset_leds5", leds5, 5'h00);
      rst_n = 1'b1;

      for (int k = 0; k < 20; k++) begin
         cfg_we = vecs[k].we; cfg_sel = vecs[k].sel; cfg_mode = vecs[k].mode; sync = vecs[k].sync;
         step();
         check($sformatf("vec%0d_leds", k), leds, vecs[k].exp_leds);
         check($sformatf("vec%0d_toggle", k), toggle, vecs[k].exp_tog);
      end
      cfg_we = 1'b0;

      pwm_run(8'd64, 64);
      pwm_run(8'd0, 0);
      pwm_run(8'd255, 255);

      // ch0 BLINK with half=0: phase flips every edge, toggle held high.
      cfg_we = 1'b1; cfg_sel = 2'd0; cfg_mode = 2'b10; cfg_half = 32'd0;
      step();
      cfg_we = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         step();
         check($sformatf("half0_led_k%0d", k), leds[0], pat_led(k, 0));
         check($sformatf("half0_tog_k%0d", k), toggle[0], 1'b1);
      end

      // Stagger all channels to BLINK half=2, then realign with sync.
      for (int c = 0; c < 4; c++) begin
         cfg_we = 1'b1; cfg_sel = 2'(c); cfg_mode = 2'b10; cfg_half = 32'd2;
         step();
      end
      cfg_we = 1'b0;
      step();
      step();
      sync = 1'b1;
      step();
      sync = 1'b0;
      check("sync_edge_toggle", toggle, 4'h0);
      for (int k = 1; k <= 9; k++) begin
         step();
         check($sformatf("sync_leds_k%0d", k), leds, pat_led(k, 2) ? 4'hF : 4'h0);
         check($sformatf("sync_tog_k%0d", k), toggle, pat_tog(k, 2) ? 4'hF : 4'h0);
      end

      // sync together with a write to ch2: ch2 goes ON, the rest restart.
      sync = 1'b1; cfg_we = 1'b1; cfg_sel = 2'd2; cfg_mode = 2'b01;
      step();
      sync = 1'b0; cfg_we = 1'b0;
      check("syncwr_edge_toggle", toggle, 4'h0);
      for (int k = 1; k <= 7; k++) begin
         step();
         el = pat_led(k, 2) ? 4'hF : 4'h0;
         el[2] = 1'b1;
         et = pat_tog(k, 2) ? 4'b1011 : 4'b0000;
         check($sformatf("syncwr_leds_k%0d", k), leds, el);
         check($sformatf("syncwr_tog_k%0d", k), toggle, et);
      end

      // Out-of-range selects on the 5-channel instance must change nothing.
      cfg_we5 = 1'b1; cfg_mode = 2'b01; cfg_half = 32'd0; cfg_duty = 8'd200;
      for (int s = 5; s < 8; s++) begin
         cfg_sel5 = 3'(s);
         step();
      end
      cfg_we5 = 1'b0;
      for (int k = 0; k < 10; k++) begin
         step();
         check($sformatf("oob_leds5_c%0d", cyc), leds5, pat_led(cyc, 3) ? 5'h1F : 5'h00);
         check($sformatf("oob_tog5_c%0d", cyc), toggle5, pat_tog(cyc, 3) ? 5'h1F : 5'h00);
      end

      // Asynchronous reset mid-period: outputs clear before the next clock edge.
      check("pre_reset_led2", leds[2], 1'b1);
      #2 rst_n = 1'b0;
      #1;
      check("async_reset_leds", leds, 4'h0);
      check("async_reset_toggle", toggle, 4'h0);
      check("async_reset_leds5", leds5, 5'h00);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         step();
         check($sformatf("rerelease_leds_k%0d", k), leds, pat_led(k, 3) ? 4'hF : 4'h0);
         check($sformatf("rerelease_tog_k%0d", k), toggle, pat_tog(k, 3) ? 4'hF : 4'h0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
